// File: rtl/button_conditioner.sv
// Turns the raw right/left/drop push-buttons into clean single-cycle game pulses.
// Each button goes through a synchroniser, a debouncer and an edge detector; left/right also auto-repeat.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250_000,
   parameter int REPEAT_DELAY    = 12_500_000,
   parameter int REPEAT_PERIOD   = 5_000_000,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic       clk_25MHz,
   input  logic       rst_n,
   input  logic       btn_right_raw,
   input  logic       btn_left_raw,
   input  logic       btn_drop_raw,
   output logic       move_right,
   output logic       move_left,
   output logic       drop_piece,
   output logic [2:0] btn_level,
   output logic [3:0] fsm_state
);

   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RCNT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
   localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } move_state_e;

   // Bit order everywhere: [0] right, [1] left, [2] drop.
   logic [2:0]        raw;
   logic [2:0]        sync1;
   logic [2:0]        sync2;
   logic [2:0]        level;
   logic [2:0]        level_d;
   logic [2:0]        rise;
   logic [DB_W-1:0]   db_cnt [3];

   move_state_e       state_q [2];
   move_state_e       state_d [2];
   logic [RCNT_W-1:0] rcnt_q [2];
   logic [RCNT_W-1:0] rcnt_d [2];
   logic [1:0]        pulse_d;

   assign raw       = {btn_drop_raw, btn_left_raw, btn_right_raw};
   assign rise      = level & ~level_d;
   assign btn_level = level;
   assign fsm_state = {state_q[1], state_q[0]};

   // Everything resets to "pressed" so a button held through reset never fires.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 3'b111;
         sync2   <= 3'b111;
         level   <= 3'b111;
         level_d <= 3'b111;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               level[i]  <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         rcnt_d[i]  = rcnt_q[i];
         pulse_d[i] = 1'b0;
         case (state_q[i])
            IDLE: begin
               if (rise[i]) begin
                  pulse_d[i] = 1'b1;
                  rcnt_d[i]  = '0;
                  state_d[i] = DELAY;
               end
            end
            DELAY: begin
               if (!level[i]) begin
                  state_d[i] = IDLE;
               end else if (REPEAT_EN) begin
                  if (rcnt_q[i] == DELAY_LAST) begin
                     pulse_d[i] = 1'b1;
                     rcnt_d[i]  = '0;
                     state_d[i] = REPEAT;
                  end else begin
                     rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
                  end
               end
            end
            REPEAT: begin
               if (!level[i]) begin
                  state_d[i] = IDLE;
               end else if (rcnt_q[i] == PERIOD_LAST) begin
                  pulse_d[i] = 1'b1;
                  rcnt_d[i]  = '0;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
               end
            end
            default: state_d[i] = IDLE;
         endcase
      end
   end

   // Move pulses are masked (not delayed) while the opposite button is held.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= IDLE;
            rcnt_q[i]  <= '0;
         end
         move_right <= 1'b0;
         move_left  <= 1'b0;
         drop_piece <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            rcnt_q[i]  <= rcnt_d[i];
         end
         move_right <= pulse_d[0] & ~level[1];
         move_left  <= pulse_d[1] & ~level[0];
         drop_piece <= rise[2];
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings.
// Expected pulses (cycle number + output pattern) are queued when stimulus is applied.
module tb_button_conditioner;

   localparam int W = 35;

   logic       clk_25MHz;
   logic       rst_n;
   logic       btn_right_raw;
   logic       btn_left_raw;
   logic       btn_drop_raw;
   logic       move_right;
   logic       move_left;
   logic       drop_piece;
   logic [2:0] btn_level;
   logic [3:0] fsm_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [W-1:0] exp_q[$];
   logic [2:0]   prev_obs = 3'b000;

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (8),
      .REPEAT_EN      (1'b1)
   ) dut (
      .clk_25MHz    (clk_25MHz),
      .rst_n        (rst_n),
      .btn_right_raw(btn_right_raw),
      .btn_left_raw (btn_left_raw),
      .btn_drop_raw (btn_drop_raw),
      .move_right   (move_right),
      .move_left    (move_left),
      .drop_piece   (drop_piece),
      .btn_level    (btn_level),
      .fsm_state    (fsm_state)
   );

   // Clock / reset block
   initial clk_25MHz = 1'b0;
   always #5 clk_25MHz = ~clk_25MHz;
   always @(posedge clk_25MHz) cyc <= cyc + 1;

   // Driver tasks: callers sit on a negedge, so the next posedge (cyc+1) samples the new value.
   task automatic set_raw(input logic r, input logic l, input logic d, output int e0);
      btn_right_raw = r;
      btn_left_raw  = l;
      btn_drop_raw  = d;
      e0 = cyc + 1;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk_25MHz);
   endtask

   task automatic push_pulse(input int c, input logic [2:0] p);
      exp_q.push_back({32'(c), p});
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every pulse observed after posedge cyc must match the queue head.
   always @(negedge clk_25MHz) begin
      logic [2:0]   obs;
      logic [W-1:0] e;
      obs = {drop_piece, move_left, move_right};
      if (obs != 3'b000) begin
         checks++;
         assert ((obs & prev_obs) == 3'b000) else begin
            errors++;
            $error("FAIL back_to_back: observed %b after %b at cyc %0d", obs, prev_obs, cyc);
         end
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pulse: observed out=%b at cyc %0d, expected none", obs, cyc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert ({32'(cyc), obs} === e) else begin
               errors++;
               $error("FAIL pulse: observed cyc=%0d out=%b expected cyc=%0d out=%b",
                      cyc, obs, e[W-1:3], e[2:0]);
            end
         end
      end
      prev_obs = obs;
   end

   initial begin
      int e0;
      int base;
      rst_n         = 1'b0;
      btn_right_raw = 1'b0;
      btn_left_raw  = 1'b0;
      btn_drop_raw  = 1'b0;
      repeat (2) @(negedge clk_25MHz);

      // Reset state
      check("reset_level", 32'(btn_level), 32'h7);
      check("reset_pulses", 32'({drop_piece, move_left, move_right}), 32'h0);
      check("reset_fsm", 32'(fsm_state), 32'h0);
      rst_n = 1'b1;
      wait_until(cyc + 10);
      check("levels_low_after_reset", 32'(btn_level), 32'h0);

      // Drop press: level at edge 5, one pulse after edge 6
      set_raw(1'b0, 1'b0, 1'b1, e0);
      push_pulse(e0 + 6, 3'b100);
      wait_until(e0 + 4);
      check("drop_level_edge4", 32'(btn_level[2]), 32'h0);
      wait_until(e0 + 5);
      check("drop_level_edge5", 32'(btn_level[2]), 32'h1);
      wait_until(e0 + 9);
      set_raw(1'b0, 1'b0, 1'b0, base);
      wait_until(e0 + 25);
      check("drop_queue_drained", 32'(exp_q.size()), 32'h0);

      // Right glitches of 1 and 3 cycles
      set_raw(1'b1, 1'b0, 1'b0, e0);
      wait_until(e0);
      set_raw(1'b0, 1'b0, 1'b0, base);
      wait_until(cyc + 10);
      check("glitch1_level", 32'(btn_level[0]), 32'h0);
      set_raw(1'b1, 1'b0, 1'b0, e0);
      wait_until(e0 + 2);
      set_raw(1'b0, 1'b0, 1'b0, base);
      wait_until(cyc + 10);
      check("glitch3_level", 32'(btn_level[0]), 32'h0);
      check("glitch3_fsm", 32'(fsm_state), 32'h0);

      // Right held 60 cycles: first pulse, delay, then periodic repeats
      set_raw(1'b1, 1'b0, 1'b0, e0);
      push_pulse(e0 + 6, 3'b001);
      for (int k = 0; k < 5; k++) push_pulse(e0 + 26 + 8 * k, 3'b001);
      wait_until(e0 + 20);
      check("right_held_level", 32'(btn_level), 32'h1);
      wait_until(e0 + 59);
      set_raw(1'b0, 1'b0, 1'b0, base);
      wait_until(base + 5);
      check("right_fsm_still_repeat", 32'(fsm_state[1:0]), 32'h2);
      wait_until(base + 6);
      check("right_fsm_idle", 32'(fsm_state[1:0]), 32'h0);
      wait_until(base + 12);
      check("right_queue_drained", 32'(exp_q.size()), 32'h0);

      // Left held, right pressed during it: conflict masking
      set_raw(1'b0, 1'b1, 1'b0, e0);
      push_pulse(e0 + 6, 3'b010);
      push_pulse(e0 + 42, 3'b010);
      push_pulse(e0 + 50, 3'b010);
      wait_until(e0 + 9);
      set_raw(1'b1, 1'b1, 1'b0, base);
      wait_until(e0 + 20);
      check("both_levels", 32'(btn_level), 32'h3);
      wait_until(e0 + 29);
      set_raw(1'b0, 1'b1, 1'b0, base);
      wait_until(e0 + 40);
      check("right_released_level", 32'(btn_level), 32'h2);
      wait_until(e0 + 50);
      set_raw(1'b0, 1'b0, 1'b0, base);
      wait_until(e0 + 70);
      check("conflict_queue_drained", 32'(exp_q.size()), 32'h0);
      check("conflict_fsm_idle", 32'(fsm_state), 32'h0);

      // Right+drop same edge, then reset while held, then a fresh drop press
      set_raw(1'b1, 1'b0, 1'b1, e0);
      push_pulse(e0 + 6, 3'b101);
      wait_until(e0 + 15);
      check("pre_reset_right_fsm", 32'(fsm_state[1:0]), 32'h1);
      rst_n = 1'b0;
      wait_until(e0 + 18);
      check("midhold_reset_level", 32'(btn_level), 32'h7);
      check("midhold_reset_fsm", 32'(fsm_state), 32'h0);
      rst_n = 1'b1;
      wait_until(e0 + 50);
      check("post_reset_level", 32'(btn_level), 32'h5);
      check("post_reset_fsm", 32'(fsm_state), 32'h0);
      set_raw(1'b0, 1'b0, 1'b0, base);
      wait_until(e0 + 65);
      check("released_levels", 32'(btn_level), 32'h0);
      set_raw(1'b0, 1'b0, 1'b1, e0);
      push_pulse(e0 + 6, 3'b100);
      wait_until(e0 + 7);
      set_raw(1'b0, 1'b0, 0, base);
      wait_until(e0 + 20);
      check("final_queue_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
